// File: rtl/ldpc_pkg.sv
// rtl/ldpc_pkg.sv - shared constants and state encoding for the LDPC frame controller
package ldpc_pkg;

  localparam int K_INFO    = 4320;
  localparam int N_PAR     = 360;
  localparam int CNT_W     = 13;
  localparam int ADDR_W    = 9;
  localparam int CLEAR_LEN = 2;

  localparam logic [1:0] ST_CLEAR  = 2'd0;
  localparam logic [1:0] ST_INFO   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;

endpackage

// File: rtl/ldpc_frame_ctrl.sv
// rtl/ldpc_frame_ctrl.sv - frames a serial info stream through the LDPC parity encoder
module ldpc_frame_ctrl
  import ldpc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic              in_bit,
  output logic              in_ready,
  output logic              enc_rst_n,
  output logic              enc_din_valid,
  output logic              enc_din,
  output logic [CNT_W-1:0]  enc_counter,
  output logic [ADDR_W-1:0] enc_out_addr,
  output logic              enc_data_valid_check,
  input  logic              enc_dout,
  output logic              out_valid,
  output logic              out_bit,
  output logic              out_sof,
  output logic              out_eof,
  output logic              out_is_parity,
  output logic              frame_err,
  output logic [15:0]       frame_cnt
);

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(K_INFO - 1);
  localparam logic [ADDR_W-1:0] ADDR_TOP = ADDR_W'(N_PAR - 1);
  localparam logic [1:0]        CLR_LAST = 2'(CLEAR_LEN - 1);

  logic [1:0] state;
  logic [1:0] clr_cnt;
  logic       synced;
  logic       info_v_q;
  logic       info_bit_q;
  logic       par_v_q;
  logic       accept;
  logic       abort;

  assign in_ready      = (state == ST_INFO);
  assign enc_rst_n     = (state != ST_CLEAR);
  assign accept        = in_valid & in_ready;
  // A fresh sof in the middle of a synced frame means upstream lost framing.
  assign abort         = accept & in_sof & synced & (enc_counter != '0);
  assign enc_din_valid = accept & (synced | in_sof) & ~abort;
  assign enc_din       = in_bit;

  // Parity bits come straight from the encoder's registered output.
  assign out_valid     = info_v_q | par_v_q;
  assign out_bit       = par_v_q ? enc_dout : info_bit_q;
  assign out_is_parity = par_v_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= ST_CLEAR;
      clr_cnt              <= '0;
      synced               <= 1'b0;
      enc_counter          <= '0;
      enc_out_addr         <= ADDR_TOP;
      enc_data_valid_check <= 1'b0;
      info_v_q             <= 1'b0;
      info_bit_q           <= 1'b0;
      par_v_q              <= 1'b0;
      out_sof              <= 1'b0;
      out_eof              <= 1'b0;
      frame_err            <= 1'b0;
      frame_cnt            <= '0;
    end else begin
      info_v_q   <= enc_din_valid;
      info_bit_q <= enc_din_valid & in_bit;
      out_sof    <= enc_din_valid & (enc_counter == '0);
      par_v_q    <= enc_data_valid_check;
      out_eof    <= 1'b0;
      frame_err  <= abort;

      case (state)
        ST_CLEAR: begin
          enc_counter <= '0;
          if (clr_cnt == CLR_LAST) begin
            clr_cnt <= '0;
            synced  <= 1'b0;
            state   <= ST_INFO;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        ST_INFO: begin
          if (abort) begin
            state       <= ST_CLEAR;
            synced      <= 1'b0;
            enc_counter <= '0;
          end else if (enc_din_valid) begin
            synced <= 1'b1;
            if (enc_counter == CNT_LAST) begin
              enc_counter          <= '0;
              synced               <= 1'b0;
              enc_data_valid_check <= 1'b1;
              state                <= ST_PARITY;
            end else begin
              enc_counter <= enc_counter + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (enc_out_addr == '0) begin
            // Final parity bit leaves on the next cycle, together with eof.
            enc_out_addr         <= ADDR_TOP;
            enc_data_valid_check <= 1'b0;
            out_eof              <= 1'b1;
            frame_cnt            <= frame_cnt + 1'b1;
            state                <= ST_CLEAR;
          end else begin
            enc_out_addr <= enc_out_addr - 1'b1;
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_ldpc_frame_ctrl.sv
// tb/tb_ldpc_frame_ctrl.sv - randomized self-checking bench for ldpc_frame_ctrl
`timescale 1ns/1ps
module tb_ldpc_frame_ctrl;
  import ldpc_pkg::*;

  localparam int CW_LEN = K_INFO + N_PAR;
  localparam int N_ROWS = K_INFO / N_PAR;

  logic clk = 1'b0;
  logic rst, in_valid, in_sof, in_bit, in_ready;
  logic enc_rst_n, enc_din_valid, enc_din, enc_data_valid_check, enc_dout;
  logic [CNT_W-1:0]  enc_counter;
  logic [ADDR_W-1:0] enc_out_addr;
  logic out_valid, out_bit, out_sof, out_eof, out_is_parity, frame_err;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  ldpc_frame_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_bit(in_bit),
    .in_ready(in_ready), .enc_rst_n(enc_rst_n), .enc_din_valid(enc_din_valid),
    .enc_din(enc_din), .enc_counter(enc_counter), .enc_out_addr(enc_out_addr),
    .enc_data_valid_check(enc_data_valid_check), .enc_dout(enc_dout),
    .out_valid(out_valid), .out_bit(out_bit), .out_sof(out_sof), .out_eof(out_eof),
    .out_is_parity(out_is_parity), .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  // Encoder stand-in: each info bit i toggles ROM row i/N_PAR rotated by i%N_PAR.
  logic [N_PAR-1:0] rom [N_ROWS];
  logic [N_PAR-1:0] enc_acc;

  function automatic logic [N_PAR-1:0] rot(input logic [N_PAR-1:0] r, input int s);
    logic [N_PAR-1:0] v;
    for (int j = 0; j < N_PAR; j++) v[j] = r[(j - s + N_PAR) % N_PAR];
    return v;
  endfunction

  always @(posedge clk) begin
    if (!enc_rst_n) enc_acc <= '0;
    else if (enc_din_valid && enc_din)
      enc_acc <= enc_acc ^ rot(rom[int'(enc_counter) / N_PAR], int'(enc_counter) % N_PAR);
    enc_dout <= enc_acc[enc_out_addr];
  end

  function automatic logic [N_PAR-1:0] ref_parity(input logic [K_INFO-1:0] info);
    logic [N_PAR-1:0] p;
    p = '0;
    for (int i = 0; i < K_INFO; i++) if (info[i]) p ^= rot(rom[i / N_PAR], i % N_PAR);
    return p;
  endfunction

  typedef struct { logic b; logic par; logic sof; logic eof; int cyc; } obs_t;
  obs_t cw[$];
  int   addr_seq[$];
  int   cyc = 0, err_pulses = 0, eof_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid) cw.push_back('{out_bit, out_is_parity, out_sof, out_eof, cyc});
    if (enc_data_valid_check) addr_seq.push_back(int'(enc_out_addr));
    if (frame_err) err_pulses++;
    if (out_eof) eof_cnt++;
  end

  int n_chk = 0, n_pass = 0, exp_frames = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    if (!in_ready) chk({tag, "_ready_timeout"}, 0, 1);
  endtask

  task automatic drive_frame(input logic [K_INFO-1:0] info, input int gap_pct,
                             input int abort_at, input int junk, input string tag);
    int cnt_err = 0, hold_err = 0, junk_err = 0;
    wait_ready(tag);
    for (int j = 0; j < junk; j++) begin
      in_valid = 1'b1; in_sof = 1'b0; in_bit = 1'($urandom);
      @(negedge clk);
      if (enc_din_valid !== 1'b0 || enc_counter != 0) junk_err++;
      tick();
    end
    for (int i = 0; i < K_INFO; i++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        in_valid = 1'b0; in_sof = 1'($urandom); in_bit = 1'($urandom);
        @(negedge clk);
        if (enc_din_valid !== 1'b0 || enc_counter != i) hold_err++;
        tick();
      end
      in_valid = 1'b1; in_bit = info[i]; in_sof = (i == 0) || (i == abort_at);
      @(negedge clk);
      if (i == abort_at) begin
        if (enc_din_valid !== 1'b0) cnt_err++;
        tick();
        break;
      end
      if (enc_din_valid !== 1'b1 || enc_counter != i) cnt_err++;
      tick();
    end
    in_valid = 1'b0; in_sof = 1'b0; in_bit = 1'b0;
    if (junk > 0) chk({tag, "_junk_dropped"}, junk_err, 0);
    if (gap_pct > 0) chk({tag, "_gap_hold"}, hold_err, 0);
    chk({tag, "_counter_seq"}, cnt_err, 0);
  endtask

  task automatic wait_eof(input string tag);
    int n = 0;
    while (!(cw.size() > 0 && cw[$].eof) && n < 3000) begin tick(); n++; end
    if (n >= 3000) chk({tag, "_eof_timeout"}, 0, 1);
  endtask

  task automatic check_cw(input logic [K_INFO-1:0] info, input string tag, input bit contig);
    logic [N_PAR-1:0] p;
    int bit_err = 0, flag_err = 0;
    p = ref_parity(info);
    chk({tag, "_len"}, cw.size(), CW_LEN);
    if (cw.size() == CW_LEN) begin
      for (int k = 0; k < CW_LEN; k++) begin
        logic eb, ep;
        if (k < K_INFO) begin eb = info[k]; ep = 1'b0; end
        else begin eb = p[N_PAR - 1 - (k - K_INFO)]; ep = 1'b1; end
        if (cw[k].b !== eb) bit_err++;
        if (cw[k].par !== ep || cw[k].sof !== (k == 0) || cw[k].eof !== (k == CW_LEN - 1))
          flag_err++;
      end
      if (contig) chk({tag, "_span"}, cw[CW_LEN-1].cyc - cw[0].cyc + 1, CW_LEN);
    end
    chk({tag, "_bits"}, bit_err, 0);
    chk({tag, "_flags"}, flag_err, 0);
  endtask

  task automatic run_frame(input logic [K_INFO-1:0] info, input int gap_pct, input int junk,
                           input string tag, input bit contig);
    int addr_err = 0;
    cw.delete();
    addr_seq.delete();
    drive_frame(info, gap_pct, -1, junk, tag);
    wait_eof(tag);
    check_cw(info, tag, contig);
    chk({tag, "_addr_len"}, addr_seq.size(), N_PAR);
    foreach (addr_seq[j]) if (addr_seq[j] != N_PAR - 1 - j) addr_err++;
    chk({tag, "_addr_sweep"}, addr_err, 0);
    exp_frames++;
    chk({tag, "_frame_cnt"}, frame_cnt, exp_frames);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_enc_rst_n"}, enc_rst_n, 0);
    chk({tag, "_counter"}, enc_counter, 0);
    chk({tag, "_addr"}, enc_out_addr, N_PAR - 1);
    chk({tag, "_dvc"}, enc_data_valid_check, 0);
    chk({tag, "_out"}, {out_valid, out_bit, out_sof, out_eof, out_is_parity, frame_err}, 0);
    chk({tag, "_frame_cnt"}, frame_cnt, 0);
  endtask

  task automatic count_clear(input string tag);
    int n = 0;
    while (!in_ready && n < 10) begin tick(); n++; end
    chk({tag, "_clear_len"}, n, CLEAR_LEN);
  endtask

  logic [K_INFO-1:0] info_a, info_b;
  logic [CW_LEN-1:0] cw_a;
  int mism, e0, p0;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_bit = 1'b0;
    for (int r = 0; r < N_ROWS; r++)
      for (int j = 0; j < N_PAR; j++) rom[r][j] = 1'($urandom);
    for (int i = 0; i < K_INFO; i++) info_a[i] = 1'($urandom);
    tick(); tick();
    check_reset_state("rst");
    rst = 1'b0;
    count_clear("rst");

    run_frame(info_a, 0, 0, "nogap", 1'b1);
    cw_a = '0;
    if (cw.size() == CW_LEN) foreach (cw[k]) cw_a[k] = cw[k].b;

    run_frame('0, 0, 0, "zero", 1'b1);
    mism = 0;
    if (cw.size() == CW_LEN) for (int j = 0; j < N_PAR; j++) if (cw[K_INFO + j].b !== 1'b0) mism++;
    chk("zero_parity_ones", mism, 0);

    info_b = '0; info_b[0] = 1'b1;
    run_frame(info_b, 0, 0, "bit0", 1'b1);
    mism = 0;
    if (cw.size() == CW_LEN)
      for (int j = 0; j < N_PAR; j++) if (cw[K_INFO + j].b !== rom[0][N_PAR - 1 - j]) mism++;
    chk("bit0_rom_row0", mism, 0);

    run_frame(info_a, 50, 0, "gap", 1'b0);
    mism = 0;
    if (cw.size() == CW_LEN) foreach (cw[k]) if (cw[k].b !== cw_a[k]) mism++;
    chk("gap_vs_nogap", mism, 0);

    for (int i = 0; i < K_INFO; i++) info_b[i] = 1'($urandom);
    run_frame(info_b, 0, 5, "junk", 1'b1);

    e0 = eof_cnt; p0 = err_pulses;
    cw.delete();
    drive_frame(info_b, 0, 1000, 0, "abort");
    chk("abort_frame_err", frame_err, 1);
    chk("abort_enc_rst_n", enc_rst_n, 0);
    count_clear("abort");
    chk("abort_err_pulses", err_pulses - p0, 1);
    chk("abort_no_eof", eof_cnt - e0, 0);
    chk("abort_fwd_bits", cw.size(), 1000);
    chk("abort_frame_cnt", frame_cnt, exp_frames);
    for (int i = 0; i < K_INFO; i++) info_b[i] = 1'($urandom);
    run_frame(info_b, 0, 0, "post_abort", 1'b1);

    e0 = eof_cnt; p0 = err_pulses;
    cw.delete();
    drive_frame(info_a, 0, -1, 0, "prst");
    begin
      int n = 0;
      while (!(enc_data_valid_check && enc_out_addr == 100) && n < 2000) begin tick(); n++; end
      chk("prst_reach_addr100", enc_out_addr, 100);
    end
    rst = 1'b1;
    tick();
    check_reset_state("prst");
    rst = 1'b0;
    exp_frames = 0;
    tick();
    chk("prst_no_eof", eof_cnt - e0, 0);
    chk("prst_no_err", err_pulses - p0, 0);
    run_frame(info_b, 0, 0, "post_rst", 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
